// File: rtl/ms7200_link_monitor_if.sv
// Request/response bundle between the link monitor and the shared iic_dri master.
// The monitor uses the master side; the iic_dri (or a model of it) uses the slave side.
interface ms7200_link_monitor_if;
  logic [7:0]  device_id;
  logic        iic_trig;
  logic        w_r;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        busy;
  logic [7:0]  data_out;
  logic        byte_over;

  modport master (
    output device_id, iic_trig, w_r, addr, data_in,
    input  busy, data_out, byte_over
  );

  modport slave (
    input  device_id, iic_trig, w_r, addr, data_in,
    output busy, data_out, byte_over
  );
endinterface

// File: rtl/ms7200_link_monitor.sv
// Post-init HDMI RX link supervisor: polls one MS7200 status register through iic_dri,
// debounces the result into link_ok and pulses reinit_req on sustained link loss.
module ms7200_link_monitor #(
  parameter logic [26:0] CLK_FRE    = 27'd10_000_000,
  parameter logic [15:0] POLL_MS    = 16'd100,
  parameter logic [15:0] TIMEOUT_MS = 16'd10,
  parameter logic [7:0]  DEVICE_ID  = 8'h56,
  parameter logic [15:0] STAT_ADDR  = 16'h0000,
  parameter logic [7:0]  STAT_MASK  = 8'h01,
  parameter logic [3:0]  STABLE_CNT = 4'd3,
  parameter logic [3:0]  LOSS_CNT   = 4'd3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init_over,
  ms7200_link_monitor_if.master        iic,
  output logic [7:0]                   status_byte,
  output logic                         link_ok,
  output logic                         reinit_req,
  output logic                         err_timeout
);

  localparam int unsigned TICK_CYC = 32'(CLK_FRE) / 32'd1000;
  localparam int unsigned MS_W     = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned CNT_W    = 4;

  localparam logic [CNT_W-1:0] WB_LAST  = 4'd15;
  localparam logic [CNT_W-1:0] CNT_SAT  = 4'hF;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_POLL = 3'd1;
  localparam logic [2:0] S_TRIG      = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_EVAL      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [15:0]      poll_cnt_q, poll_cnt_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [7:0]       sample_q, sample_d;
  logic             captured_q, captured_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic             link_ok_q, link_ok_d;
  logic             reinit_q, reinit_d;
  logic             err_q, err_d;
  logic [7:0]       status_q, status_d;
  logic             trig_q, trig_d;
  logic [15:0]      addr_q, addr_d;

  logic ms_tick_c;
  logic eval_good_c;

  // Millisecond strobe; the timebase is frozen while idle.
  assign ms_tick_c   = (state_q != S_IDLE) && (ms_cnt_q == MS_W'(TICK_CYC - 1));
  // An aborted read never counts as good, even if a byte slipped in before the abort.
  assign eval_good_c = captured_q && !abort_q && ((sample_q & STAT_MASK) == STAT_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = ms_tick_c ? '0 : ms_cnt_q + MS_W'(1);
    poll_cnt_d = ms_tick_c ? poll_cnt_q + 16'd1 : poll_cnt_q;
    to_cnt_d   = to_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    sample_d   = sample_q;
    captured_d = captured_q;
    abort_d    = abort_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    link_ok_d  = link_ok_q;
    reinit_d   = 1'b0;
    err_d      = err_q;
    status_d   = status_q;
    trig_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ms_cnt_d   = '0;
        poll_cnt_d = '0;
        if (init_over) state_d = S_WAIT_POLL;
      end

      S_WAIT_POLL: begin
        if (ms_tick_c && (poll_cnt_q == POLL_MS - 16'd1)) state_d = S_TRIG;
      end

      // Hold off while another master owns the bus, then fire a single request.
      S_TRIG: begin
        if (!iic.busy) begin
          trig_d     = 1'b1;
          wb_cnt_d   = '0;
          captured_d = 1'b0;
          abort_d    = 1'b0;
          state_d    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (iic.busy) begin
          ms_cnt_d = '0;
          to_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end else if (wb_cnt_q == WB_LAST) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_EVAL;
        end else begin
          wb_cnt_d = wb_cnt_q + 4'd1;
        end
      end

      // A byte strobe coinciding with busy falling is still captured.
      S_WAIT_DONE: begin
        if (iic.byte_over) begin
          sample_d   = iic.data_out;
          captured_d = 1'b1;
        end
        if (ms_tick_c) to_cnt_d = to_cnt_q + 16'd1;
        if (!iic.busy) begin
          state_d = S_EVAL;
        end else if (ms_tick_c && (to_cnt_q == TIMEOUT_MS - 16'd1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        ms_cnt_d   = '0;
        poll_cnt_d = '0;
        state_d    = S_WAIT_POLL;
        if (captured_q) status_d = sample_q;
        if (eval_good_c) begin
          bad_cnt_d  = '0;
          good_cnt_d = (good_cnt_q == CNT_SAT) ? good_cnt_q : good_cnt_q + 4'd1;
          if (good_cnt_d == STABLE_CNT) link_ok_d = 1'b1;
        end else begin
          good_cnt_d = '0;
          bad_cnt_d  = (bad_cnt_q == CNT_SAT) ? bad_cnt_q : bad_cnt_q + 4'd1;
          if ((bad_cnt_d == LOSS_CNT) && link_ok_q) begin
            link_ok_d = 1'b0;
            reinit_d  = 1'b1;
            bad_cnt_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Disable overrides everything, including a loss detected in the same cycle.
    if (!init_over) begin
      state_d    = S_IDLE;
      ms_cnt_d   = '0;
      poll_cnt_d = '0;
      to_cnt_d   = '0;
      wb_cnt_d   = '0;
      sample_d   = '0;
      captured_d = 1'b0;
      abort_d    = 1'b0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      link_ok_d  = 1'b0;
      reinit_d   = 1'b0;
      err_d      = 1'b0;
      status_d   = '0;
      trig_d     = 1'b0;
    end

    addr_d = ((state_d == S_TRIG) || (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_DONE))
             ? STAT_ADDR : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt_q   <= '0;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      sample_q   <= '0;
      captured_q <= 1'b0;
      abort_q    <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      link_ok_q  <= 1'b0;
      reinit_q   <= 1'b0;
      err_q      <= 1'b0;
      status_q   <= '0;
      trig_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      ms_cnt_q   <= ms_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      sample_q   <= sample_d;
      captured_q <= captured_d;
      abort_q    <= abort_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      link_ok_q  <= link_ok_d;
      reinit_q   <= reinit_d;
      err_q      <= err_d;
      status_q   <= status_d;
      trig_q     <= trig_d;
      addr_q     <= addr_d;
    end
  end

  assign iic.device_id = DEVICE_ID;
  assign iic.iic_trig  = trig_q;
  assign iic.w_r       = 1'b0;
  assign iic.addr      = addr_q;
  assign iic.data_in   = 8'h00;

  assign status_byte = status_q;
  assign link_ok     = link_ok_q;
  assign reinit_req  = reinit_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ms7200_link_monitor.sv
// Randomized bench for ms7200_link_monitor: an iic_dri responder plus a
// transaction-level model of the debounce rules (history of sample outcomes).
module tb_ms7200_link_monitor;

  localparam logic [15:0] T_ADDR = 16'hA5C3;
  localparam logic [7:0]  T_MASK = 8'h01;

  logic clk;
  logic rst_n;
  logic init_over;
  logic [7:0] status_byte;
  logic link_ok;
  logic reinit_req;
  logic err_timeout;

  ms7200_link_monitor_if bus();

  ms7200_link_monitor #(
    .CLK_FRE    (27'd1_000_000),
    .POLL_MS    (16'd2),
    .TIMEOUT_MS (16'd1),
    .DEVICE_ID  (8'h56),
    .STAT_ADDR  (T_ADDR),
    .STAT_MASK  (T_MASK),
    .STABLE_CNT (4'd3),
    .LOSS_CNT   (4'd3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_over   (init_over),
    .iic         (bus),
    .status_byte (status_byte),
    .link_ok     (link_ok),
    .reinit_req  (reinit_req),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: outcome history since the last disable or loss event.
  bit         hist[$];
  bit         m_link;
  logic [7:0] m_status;
  bit         m_err;
  int         m_re_total = 0;

  task automatic model_clear();
    hist.delete();
    m_link   = 1'b0;
    m_status = 8'h00;
    m_err    = 1'b0;
  endtask

  function automatic bit last3_all(input bit v);
    int sz;
    sz = hist.size();
    if (sz < 3) return 1'b0;
    return (hist[sz-1] == v) && (hist[sz-2] == v) && (hist[sz-3] == v);
  endfunction

  task automatic model_read(input bit captured, input logic [7:0] d, input bit timed_out,
                            output bit exp_re);
    bit good;
    good   = captured && !timed_out && ((d & T_MASK) == T_MASK);
    exp_re = 1'b0;
    if (captured)  m_status = d;
    if (timed_out) m_err = 1'b1;
    hist.push_back(good);
    if (!m_link && last3_all(1'b1)) begin
      m_link = 1'b1;
    end else if (m_link && last3_all(1'b0)) begin
      m_link = 1'b0;
      exp_re = 1'b1;
      m_re_total++;
      hist.delete();
    end
  endtask

  // Pulse monitors for iic_trig and reinit_req.
  int trig_pulses = 0;
  int re_pulses   = 0;
  int re_long     = 0;
  bit trig_prev   = 1'b0;
  bit re_prev     = 1'b0;

  always @(negedge clk) begin
    if (bus.iic_trig && !trig_prev) trig_pulses++;
    if (reinit_req && !re_prev) re_pulses++;
    if (reinit_req && re_prev) re_long++;
    trig_prev = bus.iic_trig;
    re_prev   = reinit_req;
  end

  task automatic wait_trig(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.iic_trig && n < 6000);
    if (!bus.iic_trig) chk("trig_seen", 32'd0, 32'd1);
  endtask

  // One complete read served by the responder; optionally drops init_over during EVAL.
  task automatic do_read(input logic [7:0] d, input bit drop_eval, output int lat);
    int blen;
    bit same;
    bit exp_re;
    blen = $urandom_range(2, 12);
    same = 1'($urandom_range(0, 1));
    wait_trig(lat);
    if (!bus.iic_trig) return;
    chk("trig_addr", 32'(bus.addr), 32'(T_ADDR));
    chk("trig_wr", 32'(bus.w_r), 32'd0);
    @(negedge clk);
    chk("trig_width", 32'(bus.iic_trig), 32'd0);
    bus.busy = 1'b1;
    repeat (blen) @(negedge clk);
    bus.data_out  = d;
    bus.byte_over = 1'b1;
    if (same) begin
      bus.busy = 1'b0;
      @(negedge clk);
      bus.byte_over = 1'b0;
      bus.data_out  = 8'($urandom);
    end else begin
      @(negedge clk);
      bus.byte_over = 1'b0;
      bus.busy      = 1'b0;
      bus.data_out  = 8'($urandom);
      @(negedge clk);
    end
    if (drop_eval) begin
      init_over = 1'b0;
      @(negedge clk);
      model_clear();
      chk("drop_eval_link", 32'(link_ok), 32'd0);
      chk("drop_eval_reinit", 32'(reinit_req), 32'd0);
      chk("drop_eval_status", 32'(status_byte), 32'd0);
      chk("drop_eval_err", 32'(err_timeout), 32'd0);
      return;
    end
    @(negedge clk);
    model_read(1'b1, d, 1'b0, exp_re);
    chk("rd_link", 32'(link_ok), 32'(m_link));
    chk("rd_status", 32'(status_byte), 32'(m_status));
    chk("rd_err", 32'(err_timeout), 32'(m_err));
    chk("rd_reinit", 32'(reinit_req), 32'(exp_re));
    chk("rd_addr_idle", 32'(bus.addr), 32'd0);
    if (exp_re) begin
      @(negedge clk);
      chk("reinit_width", 32'(reinit_req), 32'd0);
    end
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int tp;
    int rp;
    tp = trig_pulses;
    rp = re_pulses;
    repeat (cycles) @(negedge clk);
    chk({tag, "_no_trig"}, 32'(trig_pulses - tp), 32'd0);
    chk({tag, "_no_reinit"}, 32'(re_pulses - rp), 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    int tp;
    logic [7:0] pick [4];
    logic [7:0] t3 [5];
    bit exp_re;

    pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'h03; pick[3] = 8'hFE;
    t3[0] = 8'h01; t3[1] = 8'h00; t3[2] = 8'h01; t3[3] = 8'h01; t3[4] = 8'h01;

    rst_n = 1'b0;
    init_over = 1'b0;
    bus.busy = 1'b0;
    bus.data_out = 8'h00;
    bus.byte_over = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_link", 32'(link_ok), 32'd0);
    chk("rst_reinit", 32'(reinit_req), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_status", 32'(status_byte), 32'd0);
    chk("rst_trig", 32'(bus.iic_trig), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_devid", 32'(bus.device_id), 32'h56);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Link comes up after three good reads; first request ~2000 cycles after enable.
    init_over = 1'b1;
    do_read(8'h01, 1'b0, lat);
    chk("first_trig_lat", 32'(lat >= 1997 && lat <= 2003), 32'd1);
    do_read(8'h01, 1'b0, lat);
    do_read(8'h01, 1'b0, lat);
    chk("t1_link_up", 32'(link_ok), 32'd1);

    // Sustained loss.
    for (int i = 0; i < 3; i++) do_read(8'h00, 1'b0, lat);
    chk("t2_link_down", 32'(link_ok), 32'd0);
    chk("t2_reinit_once", 32'(re_pulses), 32'd1);

    // Interrupted run of good samples.
    tp = re_pulses;
    for (int i = 0; i < 5; i++) do_read(t3[i], 1'b0, lat);
    chk("t3_link_up", 32'(link_ok), 32'd1);
    chk("t3_no_reinit", 32'(re_pulses - tp), 32'd0);

    // Random status values.
    for (int i = 0; i < 4; i++) do_read(pick[$urandom_range(0, 3)], 1'b0, lat);

    // Responder hangs with busy high: read times out and counts as bad.
    wait_trig(lat);
    @(negedge clk);
    bus.busy = 1'b1;
    cnt = 0;
    while (!err_timeout && cnt < 1500) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_timeout_lat", 32'(cnt >= 990 && cnt <= 1010), 32'd1);
    @(negedge clk);
    model_read(1'b0, 8'h00, 1'b1, exp_re);
    chk("t4_err", 32'(err_timeout), 32'd1);
    chk("t4_link", 32'(link_ok), 32'(m_link));
    chk("t4_reinit", 32'(reinit_req), 32'(exp_re));
    bus.busy = 1'b0;

    // Another master holds busy across poll expiry.
    repeat (1980) @(negedge clk);
    bus.busy = 1'b1;
    tp = trig_pulses;
    repeat (60) @(negedge clk);
    chk("t5_held_off", 32'(trig_pulses - tp), 32'd0);
    bus.busy = 1'b0;
    do_read(8'h01, 1'b0, lat);
    chk("t5_trig_after_release", 32'(lat <= 2), 32'd1);
    chk("t5_single_trig", 32'(trig_pulses - tp), 32'd1);

    // Async reset in the middle of a read with the link up.
    for (int i = 0; i < 3; i++) do_read(8'h01, 1'b0, lat);
    wait_trig(lat);
    @(negedge clk);
    bus.busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6r_pre_link", 32'(link_ok), 32'd1);
    chk("t6r_pre_addr", 32'(bus.addr), 32'(T_ADDR));
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_link", 32'(link_ok), 32'd0);
    chk("t6r_status", 32'(status_byte), 32'd0);
    chk("t6r_err", 32'(err_timeout), 32'd0);
    chk("t6r_addr", 32'(bus.addr), 32'd0);
    @(negedge clk);
    bus.busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();

    // Disable while waiting for the byte.
    for (int i = 0; i < 3; i++) do_read(8'h01, 1'b0, lat);
    wait_trig(lat);
    @(negedge clk);
    bus.busy = 1'b1;
    repeat (4) @(negedge clk);
    init_over = 1'b0;
    @(negedge clk);
    model_clear();
    chk("t6a_link", 32'(link_ok), 32'd0);
    chk("t6a_status", 32'(status_byte), 32'd0);
    chk("t6a_err", 32'(err_timeout), 32'd0);
    chk("t6a_addr", 32'(bus.addr), 32'd0);
    repeat (3) @(negedge clk);
    bus.busy = 1'b0;
    quiet_window("t6a", 2500);

    // Disable in the same cycle as the EVAL that would signal loss.
    init_over = 1'b1;
    for (int i = 0; i < 3; i++) do_read(8'h01, 1'b0, lat);
    do_read(8'h00, 1'b0, lat);
    do_read(8'h00, 1'b0, lat);
    do_read(8'h00, 1'b1, lat);
    quiet_window("t6b", 2500);

    chk("reinit_total", 32'(re_pulses), 32'(m_re_total));
    chk("reinit_single_cycle", 32'(re_long), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
